// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: synchronise and de-glitch raw SCL/SDA, then
// decode bus conditions into single-cycle strobes for the BERT core.
module i2c_line_conditioner #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   input  logic       filter_en,
   input  logic       glitch_clr,
   output logic       scl_q,
   output logic       sda_q,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic       start_det,
   output logic       rstart_det,
   output logic       stop_det,
   output logic       bit_valid,
   output logic       bit_value,
   output logic       bus_busy,
   output logic [7:0] glitch_cnt
);

   localparam logic [3:0] FLEN = 4'(FILTER_LEN);

   // index 0 carries SCL, index 1 carries SDA
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic [1:0]             line_s;

   logic [1:0]             lvl_q, lvl_d;
   logic [1:0][3:0]        cnt_q, cnt_d;
   logic [1:0]             glitch;

   logic [1:0]             prev_q, prev_d;
   logic                   scl_rise_q, scl_rise_d;
   logic                   scl_fall_q, scl_fall_d;
   logic                   start_q, start_d;
   logic                   rstart_q, rstart_d;
   logic                   stop_q, stop_d;
   logic                   bitv_q, bitv_d;
   logic                   bitval_q, bitval_d;
   logic                   busy_q, busy_d;
   logic [7:0]             gcnt_q, gcnt_d;

   logic                   scl_hi;
   logic                   sda_fell;
   logic                   sda_rose;
   logic [8:0]             gsum;

   // shift pad levels through the synchroniser chains
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      line_s     = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};
   end

   // accept a new level only after it has held for FILTER_LEN cycles
   always_comb begin
      lvl_d  = lvl_q;
      cnt_d  = cnt_q;
      glitch = '0;
      for (int i = 0; i < 2; i++) begin
         if (!filter_en) begin
            lvl_d[i] = line_s[i];
            cnt_d[i] = '0;
         end else if (line_s[i] == lvl_q[i]) begin
            cnt_d[i]  = '0;
            glitch[i] = |cnt_q[i];
         end else if (cnt_q[i] + 4'd1 == FLEN) begin
            lvl_d[i] = line_s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
         end
      end
   end

   // decode edges and bus conditions from previous vs current levels
   always_comb begin
      prev_d     = lvl_q;
      scl_hi     = lvl_q[0] & prev_q[0];
      sda_fell   = prev_q[1] & ~lvl_q[1];
      sda_rose   = ~prev_q[1] & lvl_q[1];
      scl_rise_d = lvl_q[0] & ~prev_q[0];
      scl_fall_d = ~lvl_q[0] & prev_q[0];
      start_d    = scl_hi & sda_fell & ~busy_q;
      rstart_d   = scl_hi & sda_fell & busy_q;
      stop_d     = scl_hi & sda_rose;
      bitv_d     = scl_rise_d & busy_q;
      bitval_d   = bitv_d ? lvl_q[1] : bitval_q;
      busy_d     = busy_q;
      if (start_d) begin
         busy_d = 1'b1;
      end
      if (stop_d) begin
         busy_d = 1'b0;
      end
   end

   // saturating glitch counter, clear wins over a same-cycle glitch
   always_comb begin
      gsum = {1'b0, gcnt_q} + 9'(glitch[0]) + 9'(glitch[1]);
      if (glitch_clr) begin
         gcnt_d = '0;
      end else if (gsum[8]) begin
         gcnt_d = 8'hFF;
      end else begin
         gcnt_d = gsum[7:0];
      end
   end

   // state registers; lines idle high out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         lvl_q      <= 2'b11;
         cnt_q      <= '0;
         prev_q     <= 2'b11;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         rstart_q   <= 1'b0;
         stop_q     <= 1'b0;
         bitv_q     <= 1'b0;
         bitval_q   <= 1'b0;
         busy_q     <= 1'b0;
         gcnt_q     <= '0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         lvl_q      <= lvl_d;
         cnt_q      <= cnt_d;
         prev_q     <= prev_d;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         rstart_q   <= rstart_d;
         stop_q     <= stop_d;
         bitv_q     <= bitv_d;
         bitval_q   <= bitval_d;
         busy_q     <= busy_d;
         gcnt_q     <= gcnt_d;
      end
   end

   assign scl_q      = lvl_q[0];
   assign sda_q      = lvl_q[1];
   assign scl_rise   = scl_rise_q;
   assign scl_fall   = scl_fall_q;
   assign start_det  = start_q;
   assign rstart_det = rstart_q;
   assign stop_det   = stop_q;
   assign bit_valid  = bitv_q;
   assign bit_value  = bitval_q;
   assign bus_busy   = busy_q;
   assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb_i2c_line_conditioner: directed I2C sequences plus random pad
// activity, every cycle compared against a behavioural line model.
module tb_i2c_line_conditioner;

   localparam int SS = 2;
   localparam int FL = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl_in;
   logic       sda_in;
   logic       filter_en;
   logic       glitch_clr;
   logic       scl_q;
   logic       sda_q;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       rstart_det;
   logic       stop_det;
   logic       bit_valid;
   logic       bit_value;
   logic       bus_busy;
   logic [7:0] glitch_cnt;

   i2c_line_conditioner #(
      .SYNC_STAGES(SS),
      .FILTER_LEN (FL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .filter_en (filter_en),
      .glitch_clr(glitch_clr),
      .scl_q     (scl_q),
      .sda_q     (sda_q),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .rstart_det(rstart_det),
      .stop_det  (stop_det),
      .bit_valid (bit_valid),
      .bit_value (bit_value),
      .bus_busy  (bus_busy),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   int n_chk;
   int n_pass;
   int cyc;

   // reference model: pad history, accepted levels, run lengths
   bit hq_scl[$];
   bit hq_sda[$];
   bit m_lvl[2];
   bit m_prev[2];
   int m_run[2];
   bit m_busy;
   bit m_bval;
   bit e_rise, e_fall, e_start, e_rstart, e_stop, e_bv;
   int e_gcnt;

   // event monitor for directed checks
   int       n_start, n_rstart, n_stop, n_bits;
   int       start_cyc, stop_cyc, sda_low_cyc;
   int       busy_err;
   bit       win;
   logic [8:0] bits;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      hq_scl.delete();
      hq_sda.delete();
      for (int i = 0; i < SS; i++) begin
         hq_scl.push_back(1'b1);
         hq_sda.push_back(1'b1);
      end
      for (int i = 0; i < 2; i++) begin
         m_lvl[i]  = 1'b1;
         m_prev[i] = 1'b1;
         m_run[i]  = 0;
      end
      m_busy  = 0;
      m_bval  = 0;
      e_rise  = 0;
      e_fall  = 0;
      e_start = 0;
      e_rstart = 0;
      e_stop  = 0;
      e_bv    = 0;
      e_gcnt  = 0;
   endtask

   task automatic model_edge(input bit pc, input bit pd);
      bit s[2];
      bit nl[2];
      bit scl_hi, fell, rose;
      int gl;
      s[0] = hq_scl.pop_front();
      s[1] = hq_sda.pop_front();
      hq_scl.push_back(pc);
      hq_sda.push_back(pd);
      scl_hi   = m_lvl[0] && m_prev[0];
      fell     = m_prev[1] && !m_lvl[1];
      rose     = !m_prev[1] && m_lvl[1];
      e_rise   = m_lvl[0] && !m_prev[0];
      e_fall   = m_prev[0] && !m_lvl[0];
      e_start  = scl_hi && fell && !m_busy;
      e_rstart = scl_hi && fell && m_busy;
      e_stop   = scl_hi && rose;
      e_bv     = e_rise && m_busy;
      if (e_bv) m_bval = m_lvl[1];
      if (e_start) m_busy = 1;
      if (e_stop) m_busy = 0;
      gl = 0;
      for (int i = 0; i < 2; i++) begin
         nl[i] = m_lvl[i];
         if (!filter_en) begin
            nl[i]    = s[i];
            m_run[i] = 0;
         end else if (s[i] == m_lvl[i]) begin
            if (m_run[i] > 0) gl++;
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] >= FL) begin
               nl[i]    = s[i];
               m_run[i] = 0;
            end
         end
      end
      if (glitch_clr) e_gcnt = 0;
      else e_gcnt = (e_gcnt + gl > 255) ? 255 : e_gcnt + gl;
      m_prev = m_lvl;
      m_lvl  = nl;
   endtask

   task automatic mon_clear();
      n_start = 0; n_rstart = 0; n_stop = 0; n_bits = 0;
      start_cyc = -1; stop_cyc = -1; sda_low_cyc = -1;
      busy_err = 0; win = 0; bits = '0;
   endtask

   task automatic monitor();
      if (start_det) begin n_start++; start_cyc = cyc; end
      if (rstart_det) n_rstart++;
      if (stop_det) begin n_stop++; stop_cyc = cyc; end
      if (bit_valid) begin n_bits++; bits = {bits[7:0], bit_value}; end
      if (start_det) win = 1;
      if (stop_det) win = 0;
      if (bus_busy !== win) busy_err++;
      if (!sda_q && sda_low_cyc < 0) sda_low_cyc = cyc;
   endtask

   task automatic check_all();
      chk("scl_q", scl_q, m_lvl[0]);
      chk("sda_q", sda_q, m_lvl[1]);
      chk("scl_rise", scl_rise, e_rise);
      chk("scl_fall", scl_fall, e_fall);
      chk("start_det", start_det, e_start);
      chk("rstart_det", rstart_det, e_rstart);
      chk("stop_det", stop_det, e_stop);
      chk("bit_valid", bit_valid, e_bv);
      chk("bit_value", bit_value, m_bval);
      chk("bus_busy", bus_busy, m_busy);
      chk("glitch_cnt", glitch_cnt, e_gcnt);
   endtask

   task automatic step(input bit c, input bit d);
      scl_in = c;
      sda_in = d;
      @(posedge clk);
      cyc++;
      model_edge(c, d);
      #1;
      check_all();
      monitor();
   endtask

   task automatic hold(input bit c, input bit d, input int n);
      for (int i = 0; i < n; i++) step(c, d);
   endtask

   task automatic do_reset();
      rst_n = 0;
      scl_in = 0;
      sda_in = 0;
      glitch_clr = 0;
      filter_en = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl_q", scl_q, 1);
      chk("rst_sda_q", sda_q, 1);
      chk("rst_strobes", {scl_rise, scl_fall, start_det, rstart_det,
                          stop_det, bit_valid}, 0);
      chk("rst_bit_value", bit_value, 0);
      chk("rst_bus_busy", bus_busy, 0);
      chk("rst_glitch_cnt", glitch_cnt, 0);
      model_reset();
      scl_in = 1;
      sda_in = 1;
      rst_n = 1;
   endtask

   int         pad_cyc;
   int         pad_stop;
   bit         b;
   bit         pb;
   bit         rc;
   bit         rd;
   int         thr;
   logic [8:0] pat;

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      rst_n = 1; scl_in = 1; sda_in = 1;
      filter_en = 1; glitch_clr = 0;
      mon_clear();
      #2;
      do_reset();
      mon_clear();
      hold(1, 1, 10);
      chk("post_rst_quiet", n_start + n_stop + n_bits + n_rstart, 0);

      // START, 0xA5, ACK 0, STOP
      pat = 9'h14A;
      mon_clear();
      hold(1, 1, 20);
      pad_cyc = cyc + 1;
      hold(1, 0, 20);
      hold(0, 0, 20);
      pb = 0;
      for (int i = 8; i >= 0; i--) begin
         b = pat[i];
         hold(0, pb, 10);
         hold(0, b, 10);
         hold(1, b, 20);
         pb = b;
      end
      pad_stop = cyc + 1;
      hold(1, 1, 20);
      chk("byte_start_cnt", n_start, 1);
      chk("byte_stop_cnt", n_stop, 1);
      chk("byte_rstart_cnt", n_rstart, 0);
      chk("byte_nbits", n_bits, 9);
      chk("byte_bits", bits, pat);
      chk("byte_busy_window", busy_err, 0);
      chk("byte_start_lag", start_cyc - pad_cyc + 1, 6);
      chk("byte_stop_lag", stop_cyc - pad_stop + 1, 6);

      // repeated START
      mon_clear();
      hold(1, 1, 10);
      hold(1, 0, 20);
      hold(0, 0, 10);
      hold(0, 1, 10);
      hold(1, 1, 20);
      chk("rs_first_start", n_start, 1);
      hold(1, 0, 20);
      chk("rs_rstart", n_rstart, 1);
      chk("rs_no_start", n_start, 1);
      chk("rs_busy_held", bus_busy, 1);
      hold(0, 0, 10);
      hold(1, 0, 20);
      hold(1, 1, 20);
      chk("rs_stop", n_stop, 1);
      chk("rs_busy_clr", bus_busy, 0);
      chk("rs_busy_window", busy_err, 0);

      // glitch rejection
      glitch_clr = 1;
      step(1, 1);
      glitch_clr = 0;
      mon_clear();
      hold(1, 0, 2);
      hold(1, 1, 8);
      chk("gl_sda_cnt", glitch_cnt, 1);
      chk("gl_sda_low", sda_low_cyc, -1);
      chk("gl_no_start", n_start, 0);
      hold(0, 0, 2);
      hold(1, 1, 8);
      chk("gl_both_cnt", glitch_cnt, 3);

      // bypass
      filter_en = 0;
      hold(1, 1, 4);
      mon_clear();
      pad_cyc = cyc + 1;
      step(1, 0);
      hold(1, 1, 10);
      chk("by_start", n_start, 1);
      chk("by_stop", n_stop, 1);
      chk("by_sda_lag", sda_low_cyc - pad_cyc + 1, 3);
      chk("by_gcnt", glitch_cnt, 3);
      chk("by_busy", bus_busy, 0);
      filter_en = 1;
      hold(1, 1, 4);

      // saturation and clear priority
      for (int i = 0; i < 300; i++) begin
         step(0, 1);
         step(1, 1);
      end
      hold(1, 1, 5);
      chk("sat_cnt", glitch_cnt, 255);
      step(0, 1);
      for (int i = 0; i < SS; i++) step(1, 1);
      glitch_clr = 1;
      step(1, 1);
      glitch_clr = 0;
      chk("clr_cnt", glitch_cnt, 0);
      hold(1, 1, 4);
      chk("clr_drop", glitch_cnt, 0);

      // random pad activity
      rc = 1;
      rd = 1;
      for (int i = 0; i < 2000; i++) begin
         thr = (i < 1000) ? 7 : 2;
         if ($urandom_range(0, 199) == 0) filter_en = ~filter_en;
         glitch_clr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, thr) == 0) rc = ~rc;
         if ($urandom_range(0, thr) == 0) rd = ~rd;
         step(rc, rd);
      end
      glitch_clr = 0;
      filter_en = 1;
      hold(1, 1, 10);

      // reset mid-transfer reports no STOP
      hold(1, 0, 15);
      chk("mid_busy", bus_busy, 1);
      do_reset();
      mon_clear();
      hold(1, 1, 10);
      chk("mid_no_stop", n_stop, 0);
      chk("mid_idle", bus_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_line_conditioner.md
Name: i2c_line_conditioner

Overview:
- Front-end stage sitting between the raw SCL/SDA pad inputs (uio_in bits) and the I2C BERT core.
- Synchronises both lines and removes glitches, then decodes bus conditions for the core as single-cycle event strobes: START, repeated START, STOP, SCL edges and sampled data bits.
- Keeps a saturating glitch counter for bring-up diagnostics.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal range 2..4).
- FILTER_LEN, 3, consecutive cycles a new synchronised level must hold before it is accepted (legal range 1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scl_in  input  1  raw SCL pad level
- sda_in  input  1  raw SDA pad level
- filter_en  input  1  1 = glitch filter active, 0 = bypass (synchronised level used directly)
- glitch_clr  input  1  synchronous clear of glitch_cnt
- scl_q  output  1  conditioned SCL level
- sda_q  output  1  conditioned SDA level
- scl_rise  output  1  one-cycle strobe on a conditioned SCL 0->1 transition
- scl_fall  output  1  one-cycle strobe on a conditioned SCL 1->0 transition
- start_det  output  1  one-cycle strobe on START (idle bus)
- rstart_det  output  1  one-cycle strobe on repeated START (busy bus)
- stop_det  output  1  one-cycle strobe on STOP
- bit_valid  output  1  one-cycle strobe: data bit sampled
- bit_value  output  1  sampled SDA value, held until the next bit_valid
- bus_busy  output  1  1 between START and STOP
- glitch_cnt  output  8  saturating count of rejected glitches

Behaviour:

Reset (asynchronous assert, synchronous release via clk):
- Synchroniser flops, scl_q and sda_q reset to 1 (idle bus).
- All strobes, bus_busy, bit_value and glitch_cnt reset to 0.
- Filter counters reset to 0.
- Reset mid-transfer discards bus state; no STOP is reported.

Synchroniser:
- scl_s and sda_s are the SYNC_STAGES-deep registered copies of the pad inputs.

Filter, per line, with a 4-bit counter:
- If the synchronised level equals the conditioned level: counter = 0.
  - If the counter was non-zero in that cycle, a glitch is recorded.
- Otherwise: counter increments.
  - When counter+1 == FILTER_LEN, the conditioned level takes the synchronised value and the counter returns to 0.
- Latency from pad edge to scl_q/sda_q change is SYNC_STAGES+FILTER_LEN cycles (5 at defaults).
- filter_en = 0: conditioned level = synchronised level, registered once (latency SYNC_STAGES+1); counters held at 0; no glitches are recorded.
- A change of filter_en takes effect on the next cycle; counters clear.

Event decode:
- Registered, from the current vs previous conditioned levels.
- Each strobe is asserted the cycle after the scl_q/sda_q change.
- scl_rise / scl_fall: conditioned SCL edges, independent of bus state.
- sda_q falls while scl_q is 1 in both the previous and current cycle:
  - bus_busy = 0: start_det pulses and bus_busy is set.
  - bus_busy = 1: rstart_det pulses and bus_busy stays 1.
- sda_q rises while scl_q is 1 in both cycles: stop_det pulses and bus_busy clears. This applies even when the bus is not busy.
- SDA and SCL change in the same cycle: no START/STOP/rSTART. Only the SCL edge strobe fires.
- bit_valid pulses on scl_rise only while bus_busy = 1. bit_value = sda_q at that rise.
- start_det, rstart_det and stop_det are mutually exclusive by construction.

glitch_cnt:
- Adds the number of glitches recorded this cycle (0, 1 or 2, both lines independent).
- Saturates at 255.
- glitch_clr has priority: counter = 0 that cycle, and any simultaneous glitch is dropped.

Test Plan:
- Reset check: hold rst_n = 0 with scl_in = sda_in = 0 -> scl_q = sda_q = 1, all strobes 0, glitch_cnt = 0. Release with lines at 1 -> no strobes.
- START/byte/STOP: defaults, each SCL phase 20 cycles, send START, 0xA5, ACK 0, STOP.
  - Expect start_det once, then nine bit_valid with bit_value 1,0,1,0,0,1,0,1,0, then stop_det once.
  - bus_busy is 1 exactly between the start_det and stop_det strobes.
  - Each strobe lags its pad edge by 6 cycles.
- Repeated START: START, one bit, then SDA high->low with SCL high -> rstart_det = 1, start_det = 0, bus_busy stays 1. Then STOP -> bus_busy = 0.
- Glitch rejection: FILTER_LEN = 3, 2-cycle SDA low pulse during SCL high -> sda_q stays 1, no start_det, glitch_cnt = 1. Same 2-cycle pulse on both lines simultaneously -> glitch_cnt += 2.
- Saturation/clear: 300 single-cycle SCL glitches -> glitch_cnt = 255. Assert glitch_clr in the same cycle as a glitch -> glitch_cnt = 0 next cycle.
- Bypass: filter_en = 0, 1-cycle SDA low pulse with SCL high -> start_det then stop_det; glitch_cnt unchanged; pad-to-sda_q latency 3 cycles.
